// File: rtl/spi_mem_bridge.sv
// rtl/spi_mem_bridge.sv - CPU load/store to SPI flash (cs1) / RAM (cs2) bridge, mode 0, MSB first.
// Optional macro SPI_FAST_READ_EN: reads use 0x0B with 8 dummy bits after the address.
module spi_mem_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_request,
   input  logic        is_write,
   input  logic [2:0]  num_bytes,
   input  logic [24:0] target_address,
   input  logic [31:0] write_value,
   output logic [31:0] fetched_value,
   output logic        request_done,
   output logic        sclk,
   output logic        mosi,
   output logic        cs1,
   output logic        cs2,
   input  logic        miso
);

`ifdef SPI_FAST_READ_EN
   localparam int         TXW    = 72;
   localparam logic [7:0] RD_CMD = 8'h0B;
   localparam logic [6:0] RD_HDR = 7'd40;
`else
   localparam int         TXW    = 64;
   localparam logic [7:0] RD_CMD = 8'h03;
   localparam logic [6:0] RD_HDR = 7'd32;
`endif
   localparam logic [7:0] WR_CMD = 8'h02;
   localparam logic [6:0] WR_HDR = 7'd32;

   typedef enum logic [1:0] {IDLE, SHIFT_CMD_ADDR, SHIFT_DATA, DONE} state_t;

   state_t           state, state_n;
   logic [TXW-1:0]   tx_shift, tx_shift_n;
   logic [31:0]      rx_shift, rx_shift_n;
   logic [31:0]      fetched_n;
   logic [6:0]       bit_idx, bit_idx_n;
   logic [6:0]       last_bit, last_bit_n;
   logic [6:0]       hdr_bits, hdr_bits_n;
   logic [2:0]       n_bytes, n_bytes_n;
   logic             rd, rd_n;
   logic             sclk_n, mosi_n, cs1_n, cs2_n;

   logic [2:0]       n_eff;
   logic [5:0]       wr_shamt;
   logic [5:0]       rd_shamt;
   logic [31:0]      wr_data;
   logic [63:0]      base_tx;
   logic [TXW-1:0]   req_tx;
   logic [6:0]       req_hdr;

   // Request decode: store data is left-aligned so its first byte follows the address.
   always_comb begin
      n_eff    = (num_bytes > 3'd4) ? 3'd4 : num_bytes;
      wr_shamt = {3'd4 - n_eff, 3'b000};
      rd_shamt = {3'd4 - n_bytes, 3'b000};
      wr_data  = write_value << wr_shamt;
      req_hdr  = is_write ? WR_HDR : RD_HDR;
      base_tx  = is_write ? {WR_CMD, target_address[23:0], wr_data}
                          : {RD_CMD, target_address[23:0], 32'h0};
      req_tx   = '0;
      req_tx[TXW-1 -: 64] = base_tx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         tx_shift      <= '0;
         rx_shift      <= '0;
         fetched_value <= '0;
         bit_idx       <= '0;
         last_bit      <= '0;
         hdr_bits      <= '0;
         n_bytes       <= '0;
         rd            <= 1'b0;
         sclk          <= 1'b0;
         mosi          <= 1'b0;
         cs1           <= 1'b1;
         cs2           <= 1'b1;
      end else begin
         state         <= state_n;
         tx_shift      <= tx_shift_n;
         rx_shift      <= rx_shift_n;
         fetched_value <= fetched_n;
         bit_idx       <= bit_idx_n;
         last_bit      <= last_bit_n;
         hdr_bits      <= hdr_bits_n;
         n_bytes       <= n_bytes_n;
         rd            <= rd_n;
         sclk          <= sclk_n;
         mosi          <= mosi_n;
         cs1           <= cs1_n;
         cs2           <= cs2_n;
      end
   end

   always_comb begin
      state_n    = state;
      tx_shift_n = tx_shift;
      rx_shift_n = rx_shift;
      fetched_n  = fetched_value;
      bit_idx_n  = bit_idx;
      last_bit_n = last_bit;
      hdr_bits_n = hdr_bits;
      n_bytes_n  = n_bytes;
      rd_n       = rd;
      sclk_n     = sclk;
      mosi_n     = mosi;
      cs1_n      = cs1;
      cs2_n      = cs2;
      case (state)
         IDLE: begin
            if (start_request) begin
               // Zero-length requests and flash stores complete without touching the bus.
               if (n_eff == 3'd0 || (is_write && !target_address[24])) begin
                  state_n = DONE;
               end else begin
                  state_n    = SHIFT_CMD_ADDR;
                  tx_shift_n = req_tx;
                  rx_shift_n = '0;
                  bit_idx_n  = '0;
                  hdr_bits_n = req_hdr;
                  last_bit_n = req_hdr + {1'b0, n_eff, 3'b000} - 7'd1;
                  n_bytes_n  = n_eff;
                  rd_n       = ~is_write;
                  sclk_n     = 1'b0;
                  mosi_n     = req_tx[TXW-1];
                  cs1_n      = target_address[24];
                  cs2_n      = ~target_address[24];
               end
            end
         end
         SHIFT_CMD_ADDR, SHIFT_DATA: begin
            if (!start_request) begin
               state_n = IDLE;
               sclk_n  = 1'b0;
               mosi_n  = 1'b0;
               cs1_n   = 1'b1;
               cs2_n   = 1'b1;
            end else if (!sclk) begin
               sclk_n = 1'b1;
               if (state == SHIFT_DATA)
                  rx_shift_n = {rx_shift[30:0], miso};
            end else if (bit_idx == last_bit) begin
               state_n = DONE;
               sclk_n  = 1'b0;
               mosi_n  = 1'b0;
               cs1_n   = 1'b1;
               cs2_n   = 1'b1;
               if (rd)
                  fetched_n = rx_shift << rd_shamt;
            end else begin
               sclk_n     = 1'b0;
               bit_idx_n  = bit_idx + 7'd1;
               tx_shift_n = tx_shift << 1;
               mosi_n     = tx_shift[TXW-2];
               if (bit_idx + 7'd1 == hdr_bits)
                  state_n = SHIFT_DATA;
            end
         end
         DONE: begin
            if (!start_request)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign request_done = (state == DONE) && start_request;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb/tb_spi_mem_bridge.sv - directed self-checking bench for spi_mem_bridge with a mode-0 SPI slave model.
module tb_spi_mem_bridge;

`ifdef SPI_FAST_READ_EN
   localparam int         HDR    = 40;
   localparam logic [7:0] RD_CMD = 8'h0B;
   localparam int         LAT4   = 145;
   localparam int         LAT2   = 113;
   localparam logic [71:0] EXP_RD4 = {8'h0B, 24'h000010, 8'h00, 32'h0};
`else
   localparam int         HDR    = 32;
   localparam logic [7:0] RD_CMD = 8'h03;
   localparam int         LAT4   = 129;
   localparam int         LAT2   = 97;
   localparam logic [71:0] EXP_RD4 = {8'h00, 8'h03, 24'h000010, 32'h0};
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_request;
   logic        is_write;
   logic [2:0]  num_bytes;
   logic [24:0] target_address;
   logic [31:0] write_value;
   logic [31:0] fetched_value;
   logic        request_done;
   logic        sclk, mosi, cs1, cs2, miso;

   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          rise_cnt = 0;
   int          sclk_rises = 0;
   int          cs1_low = 0, cs2_low = 0, both_low = 0, done_hi = 0;
   int          snap_a, snap_b;
   logic [71:0] mosi_cap = '0;
   logic [31:0] miso_stream = '0;

   spi_mem_bridge dut (
      .clk(clk), .rst(rst), .start_request(start_request), .is_write(is_write),
      .num_bytes(num_bytes), .target_address(target_address), .write_value(write_value),
      .fetched_value(fetched_value), .request_done(request_done),
      .sclk(sclk), .mosi(mosi), .cs1(cs1), .cs2(cs2), .miso(miso)
   );

   always #5 clk = ~clk;

   wire cs_any = cs1 & cs2;

   // Slave: restart on chip-select fall, capture mosi on sclk rise, present miso per bit index.
   always @(posedge sclk or negedge cs_any) begin
      if (sclk) begin
         mosi_cap   = {mosi_cap[70:0], mosi};
         rise_cnt   = rise_cnt + 1;
         sclk_rises = sclk_rises + 1;
      end else begin
         mosi_cap = '0;
         rise_cnt = 0;
      end
   end

   always_comb begin
      int bi;
      miso = 1'b0;
      bi   = 31 - (rise_cnt - HDR);
      if (rise_cnt >= HDR && rise_cnt < HDR + 32)
         miso = miso_stream[bi[4:0]];
   end

   always @(negedge clk) begin
      if (!cs1) cs1_low = cs1_low + 1;
      if (!cs2) cs2_low = cs2_low + 1;
      if (!cs1 && !cs2) both_low = both_low + 1;
      if (request_done) done_hi = done_hi + 1;
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_xfer(input logic wr, input logic [2:0] n, input logic [24:0] addr,
                           input logic [31:0] wv, output int cycles);
      @(negedge clk);
      is_write       = wr;
      num_bytes      = n;
      target_address = addr;
      write_value    = wv;
      start_request  = 1'b1;
      cycles = 0;
      while (!request_done && cycles < 400) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic release_req();
      start_request = 1'b0;
      #1;
      check("done_drops_with_start", {71'b0, request_done}, 72'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start_request = 1'b0; is_write = 1'b0; num_bytes = '0;
      target_address = '0; write_value = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {66'b0, cs1, cs2, sclk, mosi, request_done, 1'b0}, {66'b0, 6'b110000});
      check("reset_fetched", {40'b0, fetched_value}, 72'd0);
      rst = 1'b0;

      // 4-byte flash read
      miso_stream = 32'h13051000;
      snap_a = cs2_low;
      run_xfer(1'b0, 3'd4, 25'h0000010, 32'h0, cyc);
      check("rd4_latency", 72'(cyc), 72'(LAT4));
      check("rd4_fetched", {40'b0, fetched_value}, {40'b0, 32'h13051000});
      check("rd4_mosi", mosi_cap, EXP_RD4);
      check("rd4_cs2_idle", 72'(cs2_low - snap_a), 72'd0);
      release_req();

      // abort during the address phase
      snap_a = done_hi;
      @(negedge clk);
      is_write = 1'b0; num_bytes = 3'd4; target_address = 25'h0000100;
      start_request = 1'b1;
      repeat (20) @(negedge clk);
      start_request = 1'b0;
      @(posedge clk);
      #1;
      check("abort_lines", {69'b0, cs1, cs2, sclk}, {69'b0, 3'b110});
      check("abort_fetched", {40'b0, fetched_value}, {40'b0, 32'h13051000});
      check("abort_no_done", 72'(done_hi - snap_a), 72'd0);
      @(negedge clk);
      @(negedge clk);

      // 1-byte RAM write
      snap_a = cs1_low; snap_b = cs2_low;
      run_xfer(1'b1, 3'd1, 25'h1000020, 32'hDEADBEEF, cyc);
      check("wr1_latency", 72'(cyc), 72'd81);
      check("wr1_mosi", mosi_cap, {32'b0, 8'h02, 24'h000020, 8'hEF});
      check("wr1_cs1_idle", 72'(cs1_low - snap_a), 72'd0);
      check("wr1_cs2_used", 72'(cs2_low - snap_b > 0), 72'd1);
      release_req();

      // 2-byte RAM read
      miso_stream = 32'hABCD0000;
      snap_a = cs1_low;
      run_xfer(1'b0, 3'd2, 25'h1000040, 32'h0, cyc);
      check("rd2_latency", 72'(cyc), 72'(LAT2));
      check("rd2_fetched", {40'b0, fetched_value}, {40'b0, 32'hABCD0000});
      check("rd2_cs1_idle", 72'(cs1_low - snap_a), 72'd0);
      check("rd2_mosi_cmd", {64'b0, mosi_cap[HDR+15 -: 8]}, {64'b0, RD_CMD});
      release_req();

      // num_bytes above 4 clamps to 4
      miso_stream = 32'h11223344;
      run_xfer(1'b0, 3'd7, 25'h1000000, 32'h0, cyc);
      check("rd7_latency", 72'(cyc), 72'(LAT4));
      check("rd7_fetched", {40'b0, fetched_value}, {40'b0, 32'h11223344});
      release_req();

      // reset during the data phase
      @(negedge clk);
      is_write = 1'b0; num_bytes = 3'd4; target_address = 25'h0000200;
      start_request = 1'b1;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_outputs", {66'b0, cs1, cs2, sclk, mosi, request_done, 1'b0}, {66'b0, 6'b110000});
      check("midrst_fetched", {40'b0, fetched_value}, 72'd0);
      start_request = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // zero-length request
      snap_a = sclk_rises;
      run_xfer(1'b0, 3'd0, 25'h1000000, 32'h0, cyc);
      check("n0_latency", 72'(cyc), 72'd1);
      check("n0_no_sclk", 72'(sclk_rises - snap_a), 72'd0);
      release_req();

      // store to flash is dropped
      snap_a = sclk_rises; snap_b = cs1_low;
      run_xfer(1'b1, 3'd2, 25'h0000050, 32'h12345678, cyc);
      check("flashwr_latency", 72'(cyc), 72'd1);
      check("flashwr_no_sclk", 72'(sclk_rises - snap_a), 72'd0);
      check("flashwr_cs1_idle", 72'(cs1_low - snap_b), 72'd0);
      release_req();

      check("never_both_cs_low", 72'(both_low), 72'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_mem_bridge.md
SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start_request  input  1  level request from CPU core; held high until request_done seen.
REQ-004 SHALL have port: is_write  input  1  1=store, 0=load/fetch; sampled with start_request.
REQ-005 SHALL have port: num_bytes  input  3  transfer length 0..4; values >4 treated as 4.
REQ-006 SHALL have port: target_address  input  25  bit 24 selects chip (0=flash/cs1, 1=RAM/cs2); [23:0] is the SPI address.
REQ-007 SHALL have port: write_value  input  32  store data, right-aligned.
REQ-008 SHALL have port: fetched_value  output  32  load data, left-aligned.
REQ-009 SHALL have port: request_done  output  1  transfer complete.
REQ-010 SHALL have ports: sclk, mosi, cs1, cs2  output  1 each; miso  input  1.

Function
REQ-011 SHALL implement a state machine: IDLE -> SHIFT_CMD_ADDR (32 bits) -> SHIFT_DATA (8*n bits) -> DONE -> IDLE.
REQ-012 IDLE: on start_request=1 with n>0, latch is_write, n, address and write_value, assert selected cs low, drive first bit on mosi at the same edge.
REQ-013 Protocol: SPI mode 0, MSB first; read cmd 0x03, write cmd 0x02; 24-bit address follows the command; data follows the address.
REQ-014 Bit timing: sclk = clk/2; each bit is 1 clk with sclk low (mosi changes here) then 1 clk with sclk high; miso sampled at the edge that raises sclk.
REQ-015 Load data: 1st received byte to fetched_value[31:24], 2nd to [23:16], etc.; unreceived low bytes are 0; fetched_value updates only on completion.
REQ-016 Store data: sends the low n bytes of write_value, most significant first (n=1: [7:0]; n=2: [15:8],[7:0]; n=4: [31:24]..[7:0]).
REQ-017 Latency: for n=1..4 without the config option, request_done SHALL rise exactly 2*(32+8n)+1 clk cycles after the edge that samples start_request.
REQ-018 On the last bit's high phase, the next edge SHALL return sclk=0, deassert cs and enter DONE.
REQ-019 request_done SHALL equal (state==DONE) AND start_request, combinationally, so it drops in the same cycle start_request falls.
REQ-020 DONE -> IDLE when start_request=0; no new transfer starts until start_request has been low for at least one cycle.
REQ-021 n=0: no SPI activity; enters DONE on the next edge.
REQ-022 Write with target_address[24]=0 (flash): dropped, no SPI activity; DONE on the next edge.
REQ-023 start_request falling mid-transfer: abort at the next edge, cs high, sclk 0, IDLE; fetched_value unchanged.
REQ-024 Idle levels: cs1=cs2=1, sclk=0, mosi=0; at most one cs low at any time.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, cs1=cs2=1, sclk=0, mosi=0, fetched_value=0, request_done=0, counters cleared, including mid-transfer.
REQ-026 Operation SHALL resume on the first edge after rst falls with start_request re-sampled.

Configuration
REQ-027 Macro SPI_FAST_READ_EN defined: reads use cmd 0x0B plus 8 dummy bits (mosi=0, miso ignored) after the address; read latency +16 clk; writes unchanged.
REQ-028 Macro undefined: reads use 0x03 with no dummy bits; REQ-017 latency holds exactly.

Verification
REQ-029 Read 4 bytes from addr 0x0000010 (cs1), miso model returns 0x13,0x05,0x10,0x00 -> cmd 0x03, addr 0x000010, fetched_value=0x13051000, done after 129 clk.
REQ-030 Write n=1, addr 0x1000020, write_value=0xDEADBEEF -> cs2 low, mosi bytes 0x02,0x00,0x00,0x20,0xEF, done after 81 clk.
REQ-031 Read n=2 from RAM, bytes 0xAB,0xCD -> fetched_value=0xABCD0000, cs1 high throughout.
REQ-032 Drop start_request mid-address -> cs high next edge, fetched_value keeps prior 0x13051000, no done pulse.
REQ-033 rst pulse during data phase -> all outputs at reset values the same cycle; n=0 request and flash write each -> done after 1 clk, no sclk toggles.
REQ-034 With SPI_FAST_READ_EN, 4-byte read -> cmd 0x0B, 8 dummy bits, done after 145 clk.
